// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the chunked multi-cycle adder:
//   state_t     - FSM state encoding (IDLE, RUN, DONE)
//   chunk_count - number of CHUNK-bit slices in a WIDTH-bit operand (N)
//   cnt_width   - bits needed for the chunk counter, $clog2(N), at least 1
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports:
//   a, b  in  CHUNK  slice operands
//   ci    in  1      carry in
//   s     out CHUNK  slice sum
//   co    out 1      carry out of the slice MSB
// -----------------------------------------------------------------------------
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
// Multi-cycle WIDTH-bit adder that processes CHUNK bits per clock through a
// single shared adder_chunk slice, carrying between slices in a register.
// An operation takes N = WIDTH/CHUNK RUN cycles followed by one DONE cycle.
// WIDTH must be a multiple of CHUNK and at least CHUNK.
//
// Optional feature macro: ADDER_SUB_EN
//   defined   - 'sub' port exists; sub=1 computes a - b (b inverted, carry-in
//               forced to 1, cin ignored); cout=1 then means "no borrow".
//   undefined - add only, cin honoured.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      request, sampled only in IDLE or DONE
//   a, b   in  WIDTH  operands, latched on an accepted start
//   cin    in  1      carry in, latched on an accepted start
//   sub    in  1      subtract select (ADDER_SUB_EN only)
//   busy   out 1      high while chunks are being computed
//   done   out 1      one-cycle pulse, result valid
//   sum    out WIDTH  result, held until the next accepted start
//   cout   out 1      carry out of the MSB
//   ovf    out 1      signed two's-complement overflow
// -----------------------------------------------------------------------------
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = chunk_count(WIDTH, CHUNK);
  localparam int CW = cnt_width(WIDTH, CHUNK);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nxt;
  logic             accept;
  logic             last;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] beff_r;   // effective B operand (inverted when subtracting)
  logic [CHUNK-1:0] ca, cb, cs;
  logic             cco;

  // Shared slice adder, operands selected by the chunk counter
  assign ca = a_r[int'(cnt)*CHUNK +: CHUNK];
  assign cb = beff_r[int'(cnt)*CHUNK +: CHUNK];

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (ca),
    .b  (cb),
    .ci (carry),
    .s  (cs),
    .co (cco)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last      = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
`ifdef ADDER_SUB_EN
      beff_r <= sub ? ~b : b;
`else
      beff_r <= b;
`endif
    end
  end

  // Chunk sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
`ifdef ADDER_SUB_EN
      carry <= sub | cin;     // subtract forces the +1 of two's complement
`else
      carry <= cin;
`endif
    end else if (state == RUN) begin
      sum[int'(cnt)*CHUNK +: CHUNK] <= cs;
      carry <= cco;
      cnt   <= cnt + 1'b1;
      if (last) begin
        cout <= cco;
        // Overflow: operands agree in sign but the result sign differs
        ovf  <= (a_r[WIDTH-1] == beff_r[WIDTH-1]) && (cs[CHUNK-1] != a_r[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_adder
// Self-checking bench for chunked_adder (WIDTH=8, CHUNK=4): reset state,
// a table of directed vectors, ignored start during RUN, back-to-back start
// through DONE, reset mid-RUN, and randomized operations against an
// arithmetic reference model. Subtract vectors are included when
// ADDER_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_chunked_adder;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = W / C;
  localparam longint MOD  = 64'sd1 << W;
  localparam longint SMAX = (64'sd1 << (W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 << (W - 1));
`ifdef ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  chunked_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a, b;
    logic         cin, sb;
    logic [W-1:0] s;
    logic         co, ov;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, input logic s,
                                output logic [W-1:0] es, output logic eco,
                                output logic eov);
    longint ua, ub, sa, sb, r, sr;
    ua = longint'(x);
    ub = longint'(y);
    sa = (ua >= MOD / 2) ? ua - MOD : ua;
    sb = (ub >= MOD / 2) ? ub - MOD : ub;
    if (s) begin
      r   = ua - ub;
      eco = (ua >= ub);
      sr  = sa - sb;
    end else begin
      r   = ua + ub + longint'(c);
      eco = (r >= MOD);
      sr  = sa + sb + longint'(c);
    end
    es  = W'(r & (MOD - 1));
    eov = (sr > SMAX) || (sr < SMIN);
  endfunction

  // Waits (bounded) for done, counting cycles and busy cycles on the way
  task automatic wait_done(input int bound, output int cyc, output int busy_n,
                           output bit both, output bit to);
    cyc = 0; busy_n = 0; both = 1'b0; to = 1'b1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (busy && done) both = 1'b1;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Single start pulse; inputs scrambled after acceptance to prove latching
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic isub,
                        output int cyc, output int busy_n,
                        output bit both, output bit to);
    a = ia; b = ib; cin = ic;
`ifdef ADDER_SUB_EN
    sub = isub;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = ~ic;
`ifdef ADDER_SUB_EN
    sub = ~isub;
`endif
    wait_done(4 * N + 8, cyc, busy_n, both, to);
  endtask

  initial begin
    int           cyc, busy_n, dcount;
    bit           both, to;
    logic [W-1:0] es, held, ra, rb;
    logic         eco, eov, rc, rs;

    // Directed vectors: expected values worked out by hand
    tbl.push_back('{"add_3c_05",   8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0});
    tbl.push_back('{"add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{"add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
    tbl.push_back('{"add_0f_01",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{"add_80_80",   8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    tbl.push_back('{"add_aa_55_c", 8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{"add_7f_7f_c", 8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1});
    tbl.push_back('{"add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
`ifdef ADDER_SUB_EN
    tbl.push_back('{"sub_05_07",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0});
    tbl.push_back('{"sub_80_01",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    tbl.push_back('{"sub_07_07",   8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{"sub_00_80_c", 8'h00, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1});
`endif

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_sum",   sum, 0);
    check("reset_flags", {busy, done, cout, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_flags", {busy, done}, 0);

    // Table-driven vectors with timing checks
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sb, cyc, busy_n, both, to);
      check({tbl[i].name, "_timeout"}, to, 0);
      check({tbl[i].name, "_latency"}, cyc, N + 1);  // N RUN cycles, then DONE
      check({tbl[i].name, "_busycyc"}, busy_n, N);
      check({tbl[i].name, "_busy_done"}, both, 0);
      check({tbl[i].name, "_sum"}, sum, tbl[i].s);
      check({tbl[i].name, "_cout_ovf"}, {cout, ovf}, {tbl[i].co, tbl[i].ov});
      held = sum;
      @(negedge clk);
      check({tbl[i].name, "_done_pulse"}, {busy, done}, 0);
      check({tbl[i].name, "_held"}, sum, held);
    end

    // Start during RUN is ignored
    a = 8'h10; b = 8'h20; cin = 1'b0;
`ifdef ADDER_SUB_EN
    sub = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4 * N + 8, cyc, busy_n, both, to);
    check("ignored_start_timeout", to, 0);
    check("ignored_start_sum", sum, 8'h30);
    @(negedge clk);
    check("ignored_start_idle", {busy, done}, 0);

    // Start held through DONE: next operation begins with no idle cycle
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(4 * N + 8, cyc, busy_n, both, to);
    check("b2b_first_timeout", to, 0);
    check("b2b_first_sum", sum, 8'h46);
    a = 8'h01; b = 8'h02;
    @(negedge clk);
    check("b2b_no_idle", {busy, done}, 2'b10);
    start = 1'b0;
    wait_done(4 * N + 8, cyc, busy_n, both, to);
    check("b2b_second_timeout", to, 0);
    check("b2b_second_latency", cyc, N);
    check("b2b_second_sum", sum, 8'h03);
    @(negedge clk);

    // Reset on the first RUN cycle discards the operation
    a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_flags", {busy, done, cout, ovf}, 0);
    dcount = 0;
    for (int k = 0; k < 4 * N + 4; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midrun_no_done", dcount, 0);

    // Randomized operations against the reference model
    for (int it = 0; it < 1200; it++) begin
      case ($urandom_range(0, 5))
        0:       ra = '1;
        1:       ra = '0;
        2:       ra = W'(MOD / 2);
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       rb = '1;
        1:       rb = W'(1);
        2:       rb = W'(MOD / 2 - 1);
        default: rb = W'($urandom);
      endcase
      rc = 1'($urandom);
      rs = HAS_SUB ? 1'($urandom) : 1'b0;
      model(ra, rb, rc, rs, es, eco, eov);
      run_op(ra, rb, rc, rs, cyc, busy_n, both, to);
      check($sformatf("rand%0d_a%0h_b%0h_c%0b_s%0b", it, ra, rb, rc, rs),
            {to, both, cout, ovf, sum}, {1'b0, 1'b0, eco, eov, es});
      check($sformatf("rand%0d_latency", it), cyc, N + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
